// File: rtl/dm_pkg.sv
// Shared definitions for the dm_port data memory: access-size encodings and FSM states.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_CLR  = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } dm_state_t;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic for dm_port: byte enables, store-lane replication,
// load extraction with sign/zero extension, and the misalignment flag.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rext,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Decode size/offset into enables, replicated store data and extended load data
    always_comb begin
        be       = 4'b1111;
        wlanes   = wdata;
        rext     = rword;
        misalign = 1'b0;
        lane_b   = rword[{addr_lo, 3'b000} +: 8];
        lane_h   = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wlanes   = {4{wdata[7:0]}};
                rext     = {{24{sign_ext & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{wdata[15:0]}};
                rext     = {{16{sign_ext & lane_h[15]}}, lane_h};
                misalign = addr_lo[0];
            end
            default: begin
                // word and the reserved encoding both behave as word accesses
                be       = 4'b1111;
                wlanes   = wdata;
                rext     = rword;
                misalign = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/dm_port.sv
// dm_port: multi-cycle data memory with req/ready handshake, wait states,
// lane handling, misalignment abort and a post-reset clearing sweep.
// Optional store tracing is compiled in when DM_TRACE_EN is defined.
module dm_port
    import dm_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 2048,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign
);

    localparam int IW = ADDR_W - 2;

    dm_state_t     state, state_nxt;
    logic [IW-1:0] clr_cnt;
    logic [3:0]    cnt;

    logic          l_we;
    logic [1:0]    l_size;
    logic          l_sext;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;

    logic [31:0]   mem [DEPTH];

    logic [IW-1:0] widx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   rext;
    logic          mis;
    logic          access;

    // upper address bits are dropped here, giving modulo-2^ADDR_W aliasing
    assign widx   = l_addr[ADDR_W-1:2];
    assign rword  = mem[widx];
    assign access = (state == S_WAIT) && (cnt == 4'd0);

    dm_lane_align u_align (
        .size     (l_size),
        .addr_lo  (l_addr[1:0]),
        .sign_ext (l_sext),
        .wdata    (l_wdata),
        .rword    (rword),
        .be       (be),
        .wlanes   (wlanes),
        .rext     (rext),
        .misalign (mis)
    );

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        ready     = (state == S_RESP);
        case (state)
            S_CLR:   if (clr_cnt == IW'(DEPTH - 1)) state_nxt = S_IDLE;
            S_IDLE:  if (req) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_CLR;
        endcase
    end

    // State register; reset always restarts the clearing sweep
    always_ff @(posedge clk) begin
        if (reset) state <= S_CLR;
        else       state <= state_nxt;
    end

    // Counters, request latch, load result and misalign flag
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt  <= '0;
            cnt      <= '0;
            l_we     <= 1'b0;
            l_size   <= '0;
            l_sext   <= 1'b0;
            l_addr   <= '0;
            l_wdata  <= '0;
            rdata    <= '0;
            misalign <= 1'b0;
        end else begin
            case (state)
                S_CLR: clr_cnt <= clr_cnt + IW'(1);
                S_IDLE: begin
                    if (req) begin
                        l_we    <= we;
                        l_size  <= size;
                        l_sext  <= sign_ext;
                        l_addr  <= addr;
                        l_wdata <= wdata;
                        cnt     <= 4'(WAIT);
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0)  cnt      <= cnt - 4'd1;
                    else if (mis)     misalign <= 1'b1;
                    else if (!l_we)   rdata    <= rext;
                end
                S_RESP: misalign <= 1'b0;
                default: ;
            endcase
        end
    end

    // Storage writes: zero sweep in CLR, enabled lanes on an aligned store access edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLR) begin
                mem[clr_cnt] <= '0;
            end else if (access && l_we && !mis) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

`ifdef DM_TRACE_EN
    // Store trace: full byte address and only the written data width
    always_ff @(posedge clk) begin
        if (!reset && access && l_we && !mis) begin
            case (l_size)
                SZ_BYTE: $display("*%h <= %h", l_addr, l_wdata[7:0]);
                SZ_HALF: $display("*%h <= %h", l_addr, l_wdata[15:0]);
                default: $display("*%h <= %h", l_addr, l_wdata);
            endcase
        end
    end
`endif

endmodule
